mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit that sits directly downstream of the register bank.
- Consumes the bank's two read-data outputs as operands and produces results into dedicated HI/LO registers.
- A later move-from-HI/LO path writes those results back to the bank's write-data port.
- Uses a start/busy/done handshake with the control unit, so the control unit stalls while an operation is in flight.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mult_div_unit.sv | 191 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// the divide-by-zero quotient pattern and a two's-complement helper.
package mdu_pkg;

  // Widest value the shared helpers handle; covers a 2*WIDTH product.
  localparam int MAX_W = 128;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  localparam logic [MAX_W-1:0] DIV0_QUOTIENT = '1;

  function automatic logic [MAX_W-1:0] neg(input logic [MAX_W-1:0] v);
    return ~v + 1'b1;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit feeding the HI/LO registers. One iteration per
// clock on magnitudes, followed by a single sign-correction/writeback edge.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cu_start,
  input  logic [1:0]       cu_op,
  input  logic             cu_writeHi,
  input  logic             cu_writeLo,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] DIV0_Q = DIV0_QUOTIENT[WIDTH-1:0];

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return WIDTH'(neg(MAX_W'(v)));
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return (2*WIDTH)'(neg(MAX_W'(v)));
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  op_e                  op_q, op_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     araw_q, araw_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  // Operand conditioning at start: magnitudes plus recorded signs.
  logic                 st_signed, st_div, st_sa, st_sb;
  logic [WIDTH-1:0]     st_amag, st_bmag;

  assign st_signed = cu_op[0];
  assign st_div    = cu_op[1];
  assign st_sa     = st_signed & operandA[WIDTH-1];
  assign st_sb     = st_signed & operandB[WIDTH-1];
  assign st_amag   = st_sa ? neg_w(operandA) : operandA;
  assign st_bmag   = st_sb ? neg_w(operandB) : operandB;

  // Multiply step: conditional add into the upper half, then shift right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring divide step: remainder in the upper half, quotient shifts into the lower.
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   div_next;

  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ok    = ~div_diff[WIDTH];
  assign div_next  = div_ok ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  logic                 op_is_div, op_is_signed;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic [2*WIDTH-1:0]   prod_fix;

  assign op_is_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);
  assign op_is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign quo_fix  = (op_is_signed && (sign_a_q ^ sign_b_q)) ? neg_w(acc_q[WIDTH-1:0])
                                                           : acc_q[WIDTH-1:0];
  assign rem_fix  = (op_is_signed && sign_a_q) ? neg_w(acc_q[2*WIDTH-1:WIDTH])
                                               : acc_q[2*WIDTH-1:WIDTH];
  assign prod_fix = (op_is_signed && (sign_a_q ^ sign_b_q)) ? neg_2w(acc_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    opnd_d   = opnd_q;
    araw_d   = araw_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cu_writeHi) hi_d = writeData;
        if (cu_writeLo) lo_d = writeData;
        if (cu_start) begin
          op_d     = op_e'(cu_op);
          sign_a_d = st_sa;
          sign_b_d = st_sb;
          div0_d   = st_div && (operandB == '0);
          araw_d   = operandA;
          opnd_d   = st_div ? st_bmag : st_amag;
          acc_d    = {{WIDTH{1'b0}}, (st_div ? st_amag : st_bmag)};
          cnt_d    = '0;
          state_d  = CALC;
        end
      end

      CALC: begin
        acc_d = op_is_div ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end

      FIX: begin
        if (op_is_div) begin
          // A zero divisor still runs the full loop; its result is forced here.
          if (div0_q) begin
            lo_d = DIV0_Q;
            hi_d = araw_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
        done_d  = 1'b1;
        dbz_d   = op_is_div && div0_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULTU;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      opnd_q   <= '0;
      araw_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
      opnd_q   <= opnd_d;
      araw_q   <= araw_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign divByZero = dbz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO results are queued at
// each start and matched against the DUT whenever done pulses.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         cu_start = 1'b0;
  logic [1:0]   cu_op = 2'b00;
  logic         cu_writeHi = 1'b0;
  logic         cu_writeLo = 1'b0;
  logic [W-1:0] operandA = '0;
  logic [W-1:0] operandB = '0;
  logic [W-1:0] writeData = '0;
  logic         busy, done, divByZero;
  logic [W-1:0] hi, lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cu_start   (cu_start),
    .cu_op      (cu_op),
    .cu_writeHi (cu_writeHi),
    .cu_writeLo (cu_writeLo),
    .operandA   (operandA),
    .operandB   (operandB),
    .writeData  (writeData),
    .busy       (busy),
    .done       (done),
    .divByZero  (divByZero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest queued result.
  always @(negedge clock) begin
    if (reset_n && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_hi", hi, e.hi);
        check("sb_lo", lo, e.lo);
        check("sb_dbz", {31'b0, divByZero}, {31'b0, e.dbz});
        check("sb_busy_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a start for one edge (E0) and queue the expected result.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz);
    exp_t e;
    cu_start = 1'b1;
    cu_op    = op;
    operandA = a;
    operandB = b;
    e.hi = ehi; e.lo = elo; e.dbz = edbz;
    exp_q.push_back(e);
    tick();
    cu_start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output bit busy_ok);
    edges = 0;
    busy_ok = 1'b1;
    while (edges < 100) begin
      tick();
      edges++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check("done_within_bound", {31'b0, done}, 32'd1);
  endtask

  initial begin
    int edges;
    bit bok;
    int dc;

    // Reset state
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_dbz", {31'b0, divByZero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // MULTU max*max with exact latency and busy coverage
    start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    check("multu_busy_after_e0", {31'b0, busy}, 32'd1);
    wait_done(edges, bok);
    check("multu_latency_edges", 32'(edges), 32'd33);
    check("multu_busy_between", {31'b0, bok}, 32'd1);
    tick();
    check("multu_done_one_cycle", {31'b0, done}, 32'd0);
    check("multu_hi_hold", hi, 32'hFFFFFFFE);

    // Signed multiply and signed divide
    start_op(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    wait_done(edges, bok);
    tick();
    start_op(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_done(edges, bok);
    tick();

    // Divide by zero
    start_op(2'b10, 32'h64, 32'd0, 32'h64, 32'hFFFFFFFF, 1'b1);
    wait_done(edges, bok);
    check("div0_latency_edges", 32'(edges), 32'd33);
    check("div0_flag", {31'b0, divByZero}, 32'd1);
    tick();
    check("div0_flag_one_cycle", {31'b0, divByZero}, 32'd0);

    // Start and MTHI while busy are dropped; operand changes after E0 ignored
    dc = done_cnt;
    start_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    operandA = 32'hDEADBEEF;
    operandB = 32'd3;
    for (int i = 0; i < 9; i++) tick();
    cu_start   = 1'b1;
    cu_op      = 2'b00;
    cu_writeHi = 1'b1;
    writeData  = 32'hAAAA;
    tick();
    cu_start   = 1'b0;
    cu_writeHi = 1'b0;
    check("busy_mthi_dropped", hi, 32'h64);
    wait_done(edges, bok);
    check("busy_start_latency", 32'(edges), 32'd23);
    for (int i = 0; i < 40; i++) tick();
    check("busy_single_done", 32'(done_cnt - dc), 32'd1);
    check("busy_idle_after", {31'b0, busy}, 32'd0);

    // Reset mid-operation
    start_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    for (int i = 0; i < 14; i++) tick();
    #2;
    reset_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    dc = done_cnt;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check("midrst_no_done", 32'(done_cnt - dc), 32'd0);

    // Signed overflow corner
    start_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    wait_done(edges, bok);
    tick();

    // MTLO together with start in IDLE
    cu_writeLo = 1'b1;
    writeData  = 32'h1234;
    start_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    cu_writeLo = 1'b0;
    check("mtlo_with_start_lo", lo, 32'h1234);
    check("mtlo_with_start_busy", {31'b0, busy}, 32'd1);
    wait_done(edges, bok);
    tick();

    // Plain MTHI in IDLE
    cu_writeHi = 1'b1;
    writeData  = 32'h5A5A0001;
    tick();
    cu_writeHi = 1'b0;
    check("mthi_idle", hi, 32'h5A5A0001);
    check("mthi_lo_kept", lo, 32'd12);

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
